// File: rtl/light_pattern_player.sv
// Plays a stored LED pattern sequence from the pattern memory s2 port, one word per dwell period.
// Latency: start sampled in cycle S -> first read in S+1, first pattern (with strobe) in S+3.
// Backpressure: none; the memory is always ready, and start is ignored while busy.
module light_pattern_player #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W:0]    length,
    input  logic [DWELL_W-1:0] dwell,
    output logic [ADDR_W-1:0]  mem_address,
    output logic               mem_chipselect,
    output logic               mem_write,
    output logic               mem_clken,
    input  logic [DATA_W-1:0]  mem_readdata,
    output logic [DATA_W-1:0]  pattern,
    output logic               pattern_strobe,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  cfg_base;
    logic [ADDR_W-1:0]  cfg_last;
    logic               cfg_loop;
    logic [DWELL_W-1:0] cfg_dm1;
    logic [DWELL_W-1:0] cfg_dm2;

    logic [ADDR_W-1:0]  idx;
    logic [DWELL_W-1:0] cnt;
    logic               tail;
    logic               rd_pend;
    logic [ADDR_W-1:0]  addr_q;
    logic               cs_q;
    logic [DATA_W-1:0]  pattern_q;
    logic               strobe_q;
    logic               done_q;

    logic               accept;
    logic               fetch_go;
    logic               tail_set;
    logic               finish;
    logic               abort;
    logic               last_entry;
    logic [ADDR_W-1:0]  idx_nxt;
    logic [ADDR_W-1:0]  len_last;
    logic [DWELL_W-1:0] dwell_eff;

    // length 0 and length 2^ADDR_W both truncate to a last index of all-ones
    assign len_last   = ADDR_W'(length - (ADDR_W+1)'(1));
    assign dwell_eff  = (dwell < DWELL_W'(2)) ? DWELL_W'(2) : dwell;
    assign last_entry = (idx == cfg_last);
    assign idx_nxt    = last_entry ? '0 : idx + ADDR_W'(1);
    assign abort      = stop && (state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt runs 0..D-1 in HOLD, starting the cycle after the first read; the
    // prefetch slot (D-2) lines the next word up with the last dwell cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fetch_go  = 1'b0;
        tail_set  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    accept    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_nxt = stop ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (tail && (cnt == '0)) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!tail && (cnt == cfg_dm2)) begin
                    if (last_entry && !cfg_loop) begin
                        tail_set = 1'b1;
                    end else begin
                        fetch_go = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_base  <= '0;
            cfg_last  <= '0;
            cfg_loop  <= 1'b0;
            cfg_dm1   <= '0;
            cfg_dm2   <= '0;
            idx       <= '0;
            cnt       <= '0;
            tail      <= 1'b0;
            rd_pend   <= 1'b0;
            addr_q    <= '0;
            cs_q      <= 1'b0;
            pattern_q <= '0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cs_q <= 1'b0;
            if (accept) begin
                cfg_base <= base_addr;
                cfg_last <= len_last;
                cfg_loop <= loop;
                cfg_dm1  <= dwell_eff - DWELL_W'(1);
                cfg_dm2  <= dwell_eff - DWELL_W'(2);
                idx      <= '0;
                addr_q   <= base_addr;
                cs_q     <= 1'b1;
            end else if (fetch_go) begin
                idx    <= idx_nxt;
                addr_q <= cfg_base + idx_nxt;
                cs_q   <= 1'b1;
            end

            if (accept) begin
                tail <= 1'b0;
            end else if (tail_set) begin
                tail <= 1'b1;
            end

            if (state == ST_FETCH) begin
                cnt <= '0;
            end else if (state == ST_HOLD) begin
                cnt <= (cnt == cfg_dm1) ? '0 : cnt + DWELL_W'(1);
            end

            // a read in flight when stop arrives is dropped so pattern stays frozen
            rd_pend  <= cs_q && !abort;
            strobe_q <= rd_pend && !abort;
            if (rd_pend && !abort) begin
                pattern_q <= mem_readdata;
            end

            done_q <= finish;
        end
    end

    assign mem_address    = addr_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = 1'b0;
    assign mem_clken      = 1'b1;
    assign pattern        = pattern_q;
    assign pattern_strobe = strobe_q;
    assign busy           = (state != ST_IDLE);
    assign done           = done_q;

endmodule

// File: doc/light_pattern_player.md
# light_pattern_player

Sequencer that plays a stored light pattern on the board LEDs. It reads 32-bit pattern words from the 128x32 on-chip pattern memory through that memory's s2 port (single-port, one-cycle read latency) and latches each word onto the `pattern` output. Each word is held for a programmable dwell time. It runs one pass or loops, under a start/stop control.

## Interface
- ADDR_W, 7: pattern memory address width (depth 2^ADDR_W = 128).
- DATA_W, 32: pattern word width.
- DWELL_W, 24: dwell counter width.

- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins playback when idle.
- stop  in  1  one-cycle pulse; aborts playback.
- loop  in  1  1 = restart at entry 0 after the last entry.
- base_addr  in  ADDR_W  first memory address of the sequence.
- length  in  ADDR_W+1  number of entries; 0 means 128.
- dwell  in  DWELL_W  cycles each pattern is shown; 0 or 1 means 2.
- mem_address  out  ADDR_W  memory address.
- mem_chipselect  out  1  read strobe to memory.
- mem_write  out  1  constant 0.
- mem_clken  out  1  constant 1.
- mem_readdata  in  DATA_W  memory read data; valid the cycle after chipselect.
- pattern  out  DATA_W  current pattern (registered).
- pattern_strobe  out  1  one-cycle pulse in the first cycle a new pattern is visible.
- busy  out  1  high from the cycle after start through the last dwell cycle.
- done  out  1  one-cycle pulse on normal completion (loop=0 only).

## Operation
- The FSM has three states:
  - IDLE: wait for start.
  - FETCH: first read.
  - HOLD: display the pattern and prefetch the next one.
- Configuration inputs (base_addr, length, dwell, loop) are registered when start is accepted. Changes while busy are ignored.
- Entry index i runs 0..L-1. mem_address = (base_addr + i) mod 128, so the address wraps 127 -> 0.
- D = max(dwell, 2). Every pattern is visible for exactly D cycles.
- During HOLD, the next entry is fetched in the second-to-last dwell cycle. Its data is latched in the last dwell cycle, so there are no gap cycles between patterns.
- After entry L-1:
  - loop=1: the next index is 0, and playback continues indefinitely.
  - loop=0: no further fetch. At the end of the last dwell, go to IDLE, pulse done, and drop busy.
- stop in any non-IDLE state goes to IDLE on the next edge. busy drops and chipselect is deasserted. pattern keeps its last value. done is not pulsed and pattern_strobe is not pulsed.
- stop and start asserted in the same cycle: stop wins, and start is ignored.
- start while busy is ignored. stop while IDLE has no effect.
- pattern is never cleared except by reset. It holds its value after done or stop.
- mem_chipselect is high only in fetch cycles, one cycle per entry. mem_address is don't-care when chipselect is low; the RTL drives it to the last value.

## Timing
- Reset (async assert, sync release): state IDLE; pattern=0; pattern_strobe=0; busy=0; done=0; mem_chipselect=0; mem_address=0. Reset mid-playback aborts immediately.
- Let start be sampled high in cycle S:
  - Cycle S+1: FETCH, chipselect=1, address=base, busy=1.
  - Cycle S+2: readdata valid; latched at the end of the cycle.
  - Cycle S+3: pattern = word 0, pattern_strobe=1.
- Pattern k is visible from cycle S+3+kD to S+2+(k+1)D.
- Pattern k+1 is fetched (chipselect) in cycle S+1+(k+1)D.
- With loop=0, done=1 and busy=0 in cycle S+3+L·D.
- Playback can restart at the earliest with a start in the cycle where done=1.

## Test plan
- Reset: drive reset_n low mid-HOLD with pattern non-zero -> all outputs return to their reset values asynchronously; after release, the block stays IDLE until start.
- Single pass: preload memory words 5,6,7 with 0xA5A5_0005, 0xA5A5_0006, 0xA5A5_0007; set base=5, length=3, dwell=4, loop=0, start at S -> pattern_strobe pulses at S+3, S+7, S+11 with those values; done pulses at S+15; busy=0 from S+15; pattern stays 0xA5A5_0007.
- Wrap: base=126, length=4, dwell=3 -> chipselect addresses 126, 127, 0, 1 in cycles S+1, S+4, S+7, S+10.
- Loop + stop: base=0, length=2, dwell=0 (D=2), loop=1 -> patterns alternate word0/word1 every 2 cycles for at least 10 strobes; a stop pulse gives busy=0 next cycle, pattern frozen, no done pulse.
- Full depth: length=0, dwell=2, loop=0 -> exactly 128 strobes, addresses base..base+127 mod 128, done at S+3+256.
- Collisions: start and stop in the same cycle from IDLE -> stays IDLE. start during playback -> no restart, and timing is unchanged. Changing dwell mid-run -> no effect.
